// File: rtl/intra16_sad_sched.sv
// Intra 16x16 SAD sequencer: streams V/H/DC residual rows, accumulates per-mode SAD
// and picks the cheapest mode (ties favour the lower mode number).
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_RUN   | issuing one row read per cycle for each enabled mode
//   S_DRAIN | absorbing the last returned row
//   S_DONE  | results published, done pulse
module intra16_sad_sched #(
    parameter int RES_W = 9,
    parameter int SAD_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 top_avail,
    input  logic                 left_avail,
    output logic                 rd_en,
    output logic [1:0]           rd_mode,
    output logic [3:0]           rd_row,
    input  logic [16*RES_W-1:0]  rd_data,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           best_mode,
    output logic [SAD_W-1:0]     best_sad,
    output logic [SAD_W-1:0]     sad_v,
    output logic [SAD_W-1:0]     sad_h,
    output logic [SAD_W-1:0]     sad_dc
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] M_V  = 2'd0;
    localparam logic [1:0] M_H  = 2'd1;
    localparam logic [1:0] M_DC = 2'd2;

    localparam int ROW_W = RES_W + 3;
    localparam logic [RES_W-1:0] NEG_MAX  = {1'b1, {(RES_W-1){1'b0}}};
    localparam logic [SAD_W-1:0] SAD_NONE = '1;

    logic [1:0]       state;
    logic             top_en, left_en;
    logic             pend_vld;
    logic [1:0]       pend_mode;
    logic [SAD_W-1:0] acc_v, acc_h, acc_dc;
    logic [SAD_W-1:0] nxt_v, nxt_h, nxt_dc;
    logic [SAD_W-1:0] res_v, res_h, res_dc;
    logic [SAD_W-1:0] sel_sad;
    logic [1:0]       sel_mode;
    logic [1:0]       first_mode, next_mode;
    logic [ROW_W-1:0] row_sum;
    logic [RES_W-1:0] smp;
    logic [RES_W-2:0] mag;

    // |x| with -2^(RES_W-1) clamped so the magnitude always fits RES_W-1 bits
    always_comb begin
        row_sum = '0;
        smp     = '0;
        mag     = '0;
        for (int k = 0; k < 16; k++) begin
            smp = rd_data[k*RES_W +: RES_W];
            if (smp == NEG_MAX)
                mag = '1;
            else if (smp[RES_W-1])
                mag = ~smp[RES_W-2:0] + {{(RES_W-2){1'b0}}, 1'b1};
            else
                mag = smp[RES_W-2:0];
            row_sum = row_sum + {4'b0000, mag};
        end
    end

    always_comb begin
        nxt_v  = acc_v;
        nxt_h  = acc_h;
        nxt_dc = acc_dc;
        if (pend_vld) begin
            case (pend_mode)
                M_V:     nxt_v  = acc_v  + SAD_W'(row_sum);
                M_H:     nxt_h  = acc_h  + SAD_W'(row_sum);
                M_DC:    nxt_dc = acc_dc + SAD_W'(row_sum);
                default: ;
            endcase
        end
    end

    always_comb begin
        first_mode = top_avail ? M_V : (left_avail ? M_H : M_DC);
        next_mode  = (rd_mode == M_V && left_en) ? M_H : M_DC;
    end

    // A disabled mode reports all-ones, which no real SAD (max 65280) can reach
    always_comb begin
        res_v    = top_en  ? nxt_v : SAD_NONE;
        res_h    = left_en ? nxt_h : SAD_NONE;
        res_dc   = nxt_dc;
        sel_mode = M_V;
        sel_sad  = res_v;
        if (res_h < sel_sad) begin
            sel_mode = M_H;
            sel_sad  = res_h;
        end
        if (res_dc < sel_sad) begin
            sel_mode = M_DC;
            sel_sad  = res_dc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            top_en    <= 1'b0;
            left_en   <= 1'b0;
            pend_vld  <= 1'b0;
            pend_mode <= M_V;
            acc_v     <= '0;
            acc_h     <= '0;
            acc_dc    <= '0;
            rd_en     <= 1'b0;
            rd_mode   <= M_V;
            rd_row    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            best_mode <= M_DC;
            best_sad  <= '0;
            sad_v     <= '0;
            sad_h     <= '0;
            sad_dc    <= '0;
        end else begin
            pend_vld  <= rd_en;
            pend_mode <= rd_mode;
            done      <= 1'b0;
            acc_v     <= nxt_v;
            acc_h     <= nxt_h;
            acc_dc    <= nxt_dc;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        top_en  <= top_avail;
                        left_en <= left_avail;
                        acc_v   <= '0;
                        acc_h   <= '0;
                        acc_dc  <= '0;
                        rd_en   <= 1'b1;
                        rd_mode <= first_mode;
                        rd_row  <= '0;
                        busy    <= 1'b1;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (rd_row == 4'd15) begin
                        rd_row <= '0;
                        if (rd_mode == M_DC) begin
                            rd_en   <= 1'b0;
                            rd_mode <= M_V;
                            state   <= S_DRAIN;
                        end else begin
                            rd_mode <= next_mode;
                        end
                    end else begin
                        rd_row <= rd_row + 4'd1;
                    end
                end
                S_DRAIN: begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    sad_v     <= res_v;
                    sad_h     <= res_h;
                    sad_dc    <= res_dc;
                    best_mode <= sel_mode;
                    best_sad  <= sel_sad;
                    state     <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intra16_sad_sched.sv
// Self-checking bench for intra16_sad_sched: a residual memory answers reads one cycle
// late; expected SADs, read order and timing come from a plain arithmetic model.
module tb_intra16_sad_sched;

    localparam int RES_W = 9;
    localparam int SAD_W = 16;

    logic                clk = 1'b0;
    logic                reset, start, top_avail, left_avail;
    logic                rd_en;
    logic [1:0]          rd_mode;
    logic [3:0]          rd_row;
    logic [16*RES_W-1:0] rd_data;
    logic                busy, done;
    logic [1:0]          best_mode;
    logic [SAD_W-1:0]    best_sad, sad_v, sad_h, sad_dc;

    intra16_sad_sched #(.RES_W(RES_W), .SAD_W(SAD_W)) dut (
        .clk(clk), .reset(reset), .start(start), .top_avail(top_avail),
        .left_avail(left_avail), .rd_en(rd_en), .rd_mode(rd_mode), .rd_row(rd_row),
        .rd_data(rd_data), .busy(busy), .done(done), .best_mode(best_mode),
        .best_sad(best_sad), .sad_v(sad_v), .sad_h(sad_h), .sad_dc(sad_dc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic signed [RES_W-1:0] mem [3][16][16];

    function automatic logic [16*RES_W-1:0] garbage_row();
        logic [16*RES_W-1:0] p;
        for (int k = 0; k < 16; k++) p[k*RES_W +: RES_W] = RES_W'($urandom);
        return p;
    endfunction

    function automatic logic [16*RES_W-1:0] pack_row(int m, int r);
        logic [16*RES_W-1:0] p;
        if (m > 2) return garbage_row();
        for (int k = 0; k < 16; k++) p[k*RES_W +: RES_W] = mem[m][r][k];
        return p;
    endfunction

    // Residual buffer: data for a request appears one cycle later; junk otherwise
    always @(posedge clk) begin
        if (rd_en) rd_data <= pack_row(int'(rd_mode), int'(rd_row));
        else       rd_data <= garbage_row();
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rd_en"},     32'(rd_en),     0);
        check({tag, "_busy"},      32'(busy),      0);
        check({tag, "_done"},      32'(done),      0);
        check({tag, "_rd_mode"},   32'(rd_mode),   0);
        check({tag, "_rd_row"},    32'(rd_row),    0);
        check({tag, "_best_mode"}, 32'(best_mode), 2);
        check({tag, "_best_sad"},  32'(best_sad),  0);
        check({tag, "_sad_v"},     32'(sad_v),     0);
        check({tag, "_sad_h"},     32'(sad_h),     0);
        check({tag, "_sad_dc"},    32'(sad_dc),    0);
    endtask

    task automatic fill_const(input int m, input int v);
        for (int r = 0; r < 16; r++)
            for (int k = 0; k < 16; k++) mem[m][r][k] = RES_W'(v);
    endtask

    task automatic fill_rand(input int m);
        for (int r = 0; r < 16; r++)
            for (int k = 0; k < 16; k++) mem[m][r][k] = RES_W'($urandom);
    endtask

    function automatic int ref_sad(int m);
        int s = 0;
        for (int r = 0; r < 16; r++)
            for (int k = 0; k < 16; k++) begin
                int v = int'(mem[m][r][k]);
                if (v < 0)   v = -v;
                if (v > 255) v = 255;
                s += v;
            end
        return s;
    endfunction

    task automatic run(input bit top, input bit left, input int restart_at, input int rst_at);
        int modes[$];
        int n, lim, ev, eh, edc, ebm, ebs, mn;
        int seq_err = 0, busy_err = 0, done_cnt = 0, done_k = -1;
        logic [SAD_W-1:0] cv = '0, ch = '0, cdc = '0, cbs = '0;
        logic [1:0] cbm = '0;
        bit exp_rd, exp_busy;

        if (top)  modes.push_back(0);
        if (left) modes.push_back(1);
        modes.push_back(2);
        n   = modes.size();
        lim = 16*n + 6;
        ev  = top  ? ref_sad(0) : 'hFFFF;
        eh  = left ? ref_sad(1) : 'hFFFF;
        edc = ref_sad(2);
        mn  = ev;
        if (eh < mn)  mn = eh;
        if (edc < mn) mn = edc;
        ebm = (ev == mn) ? 0 : ((eh == mn) ? 1 : 2);
        ebs = mn;

        @(negedge clk);
        start = 1'b1; top_avail = top; left_avail = left;
        for (int k = 1; k <= lim; k++) begin
            @(negedge clk);
            exp_rd   = (k <= 16*n)     && !(rst_at >= 0 && k > rst_at);
            exp_busy = (k <= 16*n + 1) && !(rst_at >= 0 && k > rst_at);
            if (rd_en !== exp_rd) seq_err++;
            else if (exp_rd) begin
                if (rd_mode !== 2'(modes[(k-1)/16]) || rd_row !== 4'((k-1) % 16)) seq_err++;
            end
            if (busy !== exp_busy) busy_err++;
            if (done === 1'b1) begin
                done_cnt++; done_k = k;
                cv = sad_v; ch = sad_h; cdc = sad_dc; cbm = best_mode; cbs = best_sad;
            end
            if (rst_at >= 0 && k == rst_at + 1) begin
                check_reset_vals("mid_reset");
                reset = 1'b0;
            end
            start = (k == restart_at);
            if (k == rst_at) reset = 1'b1;
            top_avail  = 1'($urandom);
            left_avail = 1'($urandom);
        end
        start = 1'b0;

        check("read_sequence", 32'(seq_err),  0);
        check("busy_window",   32'(busy_err), 0);
        if (rst_at >= 0) begin
            check("no_done_after_reset", 32'(done_cnt), 0);
        end else begin
            check("done_count", 32'(done_cnt), 1);
            check("done_cycle", 32'(done_k),   32'(16*n + 2));
            check("sad_v",      32'(cv),  32'(ev));
            check("sad_h",      32'(ch),  32'(eh));
            check("sad_dc",     32'(cdc), 32'(edc));
            check("best_mode",  32'(cbm), 32'(ebm));
            check("best_sad",   32'(cbs), 32'(ebs));
            check("hold_sad_dc",    32'(sad_dc),    32'(edc));
            check("hold_best_mode", 32'(best_mode), 32'(ebm));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; top_avail = 1'b0; left_avail = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;

        // all zero, ties resolve to V
        fill_const(0, 0); fill_const(1, 0); fill_const(2, 0);
        run(1, 1, -1, -1);

        fill_const(0, 3); fill_const(1, -2); fill_const(2, 1);
        run(1, 1, -1, -1);

        fill_rand(0); fill_const(1, 1); fill_const(2, 1);
        run(0, 1, -1, -1);

        fill_rand(0); fill_rand(1); fill_const(2, -255);
        run(0, 0, -1, -1);
        fill_const(2, -256);
        run(0, 0, -1, -1);

        for (int i = 0; i < 6; i++) begin
            fill_rand(0); fill_rand(1); fill_rand(2);
            run(1'($urandom), 1'($urandom), -1, -1);
        end

        // start pulses in RUN, DRAIN and DONE are ignored
        fill_rand(0); fill_rand(1); fill_rand(2);
        run(1, 1, 10, -1);
        run(1, 1, 49, -1);
        run(0, 1, 34, -1);

        fill_rand(0); fill_rand(1); fill_rand(2);
        run(1, 1, -1, 20);
        run(1, 1, -1, -1);

        // reset wins over a simultaneous start
        @(negedge clk);
        reset = 1'b1; start = 1'b1; top_avail = 1'b1; left_avail = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("rst_start_rd_en", 32'(rd_en), 0);
        check("rst_start_busy",  32'(busy),  0);
        @(negedge clk);
        check("rst_start_idle_rd_en", 32'(rd_en), 0);
        check("rst_start_idle_busy",  32'(busy),  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
